// File: rtl/satarx_crc.sv
// rtl/satarx_crc.sv - SATA RX CRC-32 checker/stripper; optional stats via SATARX_CRC_STATS_EN
module satarx_crc #(
  parameter logic        OPT_LOWPOWER = 1'b0,
  parameter logic [31:0] P_CRC_INIT   = 32'h52325032,
  parameter logic [31:0] P_CRC_POLY   = 32'h04C11DB7
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        S_AXIS_TVALID,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TABORT,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TABORT,
  output logic        o_crc_err
`ifdef SATARX_CRC_STATS_EN
  ,
  output logic [15:0] o_err_count
`endif
);

  // Bit-serial CRC, bit 31 of the word enters first, no reflection.
  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? P_CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic [31:0] crc_q, crc_d;
  logic        in_frame_q, in_frame_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        m_abort_q, m_abort_d;
  logic        crc_err_q, crc_err_d;

  // Next-state: abort beats everything, then non-last and last beats; idle holds state.
  always_comb begin
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    crc_d      = crc_q;
    in_frame_d = in_frame_q;
    m_valid_d  = 1'b0;
    m_data_d   = OPT_LOWPOWER ? 32'h0 : m_data_q;
    m_last_d   = 1'b0;
    m_abort_d  = 1'b0;
    crc_err_d  = 1'b0;

    if (S_AXIS_TABORT) begin
      if (in_frame_q || r_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = 32'h0;
        m_last_d  = 1'b1;
        m_abort_d = 1'b1;
      end
      r_valid_d  = 1'b0;
      in_frame_d = 1'b0;
      crc_d      = P_CRC_INIT;
    end else if (S_AXIS_TVALID && !S_AXIS_TLAST) begin
      in_frame_d = 1'b1;
      if (r_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = r_data_q;
      end
      r_data_d  = S_AXIS_TDATA;
      r_valid_d = 1'b1;
      crc_d     = crc_next(crc_q, S_AXIS_TDATA);
    end else if (S_AXIS_TVALID && S_AXIS_TLAST) begin
      m_valid_d = 1'b1;
      m_last_d  = 1'b1;
      if (r_valid_q) begin
        m_data_d  = r_data_q;
        m_abort_d = (crc_q != S_AXIS_TDATA);
        crc_err_d = (crc_q != S_AXIS_TDATA);
      end else begin
        // Runt: only the CRC word arrived, there is no payload to carry TLAST.
        m_data_d  = 32'h0;
        m_abort_d = 1'b1;
      end
      r_valid_d  = 1'b0;
      in_frame_d = 1'b0;
      crc_d      = P_CRC_INIT;
    end
  end

  // State and registered outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_valid_q  <= 1'b0;
      r_data_q   <= 32'h0;
      crc_q      <= P_CRC_INIT;
      in_frame_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 32'h0;
      m_last_q   <= 1'b0;
      m_abort_q  <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      crc_q      <= crc_d;
      in_frame_q <= in_frame_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_abort_q  <= m_abort_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TABORT = m_abort_q;
  assign o_crc_err     = crc_err_q;

`ifdef SATARX_CRC_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        cnt_inc;

  // Saturating count of CRC mismatches plus runt frames.
  always_comb begin
    cnt_inc   = crc_err_d |
                (!S_AXIS_TABORT && S_AXIS_TVALID && S_AXIS_TLAST && !r_valid_q);
    err_cnt_d = err_cnt_q;
    if (cnt_inc && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      err_cnt_q <= 16'h0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_satarx_crc.sv
// tb/tb_satarx_crc.sv - scoreboard bench for satarx_crc
module tb_satarx_crc;

  localparam logic [31:0] SEED = 32'h52325032;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        a;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid, s_tlast, s_tabort;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tabort, crc_err;
  logic [31:0] m_tdata;
`ifdef SATARX_CRC_STATS_EN
  logic [15:0] err_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_stats = 0;
  exp_t        exp_q[$];
  exp_t        e_mon;
  logic [31:0] pay[$];

  always #5 clk = ~clk;

  satarx_crc dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (resetn),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TABORT (s_tabort),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TABORT (m_tabort),
    .o_crc_err     (crc_err)
`ifdef SATARX_CRC_STATS_EN
    ,
    .o_err_count   (err_count)
`endif
  );

  // Whole-word formulation of the MSB-first CRC: fold the word in, then shift 32 times.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic l, input logic a);
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tabort = a;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tdata = 32'h0; s_tlast = 1'b0; s_tabort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Sends pay[] plus its CRC word (optionally with bit 0 flipped), pushing the expected output.
  task automatic send_frame(input bit corrupt, input bit gaps);
    logic [31:0] crc;
    crc = SEED;
    for (int i = 0; i < pay.size(); i++) begin
      if (gaps) idle($urandom_range(0, 2));
      crc = model_crc(crc, pay[i]);
      if (i > 0) exp_q.push_back('{d: pay[i-1], l: 1'b0, a: 1'b0, e: 1'b0});
      beat(1'b1, pay[i], 1'b0, 1'b0);
    end
    if (pay.size() == 0) begin
      exp_q.push_back('{d: 32'h0, l: 1'b1, a: 1'b1, e: 1'b0});
      exp_stats++;
    end else begin
      exp_q.push_back('{d: pay[pay.size()-1], l: 1'b1, a: corrupt, e: corrupt});
      if (corrupt) exp_stats++;
    end
    beat(1'b1, crc ^ {31'h0, corrupt}, 1'b1, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_tvalid"}, {63'h0, m_tvalid}, 64'h0);
    chk({tag, "_tdata"}, {32'h0, m_tdata}, 64'h0);
    chk({tag, "_tlast"}, {63'h0, m_tlast}, 64'h0);
    chk({tag, "_tabort"}, {63'h0, m_tabort}, 64'h0);
    chk({tag, "_crc_err"}, {63'h0, crc_err}, 64'h0);
  endtask

  initial begin
    resetn = 1'b0;
    s_tvalid = 1'b0; s_tdata = 32'h0; s_tlast = 1'b0; s_tabort = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (resetn) begin
          if (m_tvalid) begin
            chk("out_expected", {63'h0, exp_q.size() != 0}, 64'h1);
            if (exp_q.size() != 0) begin
              e_mon = exp_q.pop_front();
              chk("out_beat", {29'h0, m_tdata, m_tlast, m_tabort, crc_err}, {29'h0, e_mon});
            end
          end else begin
            chk("idle_quiet", {61'h0, m_tlast, m_tabort, crc_err}, 64'h0);
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
`ifdef SATARX_CRC_STATS_EN
    chk("reset_err_count", {48'h0, err_count}, 64'h0);
`endif
    resetn = 1'b1;
    idle(2);

    // 1: clean three-word frame
    pay = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    send_frame(1'b0, 1'b0);
    idle(3);

    // 2: same frame with a flipped CRC bit
    send_frame(1'b1, 1'b0);
    idle(3);

    // 3: runt (CRC word only)
    pay = {};
    send_frame(1'b0, 1'b0);
    idle(3);

    // 4: abort after two words, then a good frame
    exp_q.push_back('{d: 32'h1111_2222, l: 1'b0, a: 1'b0, e: 1'b0});
    beat(1'b1, 32'h1111_2222, 1'b0, 1'b0);
    beat(1'b1, 32'h3333_4444, 1'b0, 1'b0);
    exp_q.push_back('{d: 32'h0, l: 1'b1, a: 1'b1, e: 1'b0});
    beat(1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
    // Abort while idle produces nothing.
    beat(1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
    pay = '{32'hDEAD_BEEF, 32'h0123_4567};
    send_frame(1'b0, 1'b0);
    idle(3);

    // 5: reset mid-frame, then a clean frame from a fresh seed
    exp_q.push_back('{d: 32'h5555_0001, l: 1'b0, a: 1'b0, e: 1'b0});
    beat(1'b1, 32'h5555_0001, 1'b0, 1'b0);
    beat(1'b1, 32'h5555_0002, 1'b0, 1'b0);
    idle(1);
    resetn = 1'b0;
    idle(2);
    check_reset_state("midreset");
`ifdef SATARX_CRC_STATS_EN
    chk("midreset_err_count", {48'h0, err_count}, 64'h0);
    exp_stats = 0;
`endif
    resetn = 1'b1;
    idle(1);
    pay = '{32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 32'h7777_0004};
    send_frame(1'b0, 1'b0);
    idle(3);

    // 6: back-to-back long random frames with idle gaps
    for (int f = 0; f < 3; f++) begin
      pay = {};
      for (int i = 0; i < 1000; i++) pay.push_back($urandom);
      send_frame(1'b0, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(5);

    chk("queue_drained", {32'h0, exp_q.size()}, 64'h0);
`ifdef SATARX_CRC_STATS_EN
    chk("err_count", {48'h0, err_count}, {32'h0, exp_stats});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
